conv_pixel_sched: RTL and testbench
===================================

CONV_PIXEL_SCHED -- requirements
Module: conv_pixel_sched

Interface
REQ-001 The module SHALL have parameter K, default 3, meaning the kernel edge, so that K*K taps of 4 lanes each are issued per output pixel.
REQ-002 The module SHALL have parameter PW, default 12, meaning the pixel-count and out_fm address width.
REQ-003 The module SHALL have parameter AW, default 16, meaning the in_fm buffer address width.
REQ-004 The module SHALL have parameter ACC_DELAY, default 50, meaning cycles from issuing a pixel's last tap to its accumulator result being valid.
REQ-005 The module SHALL have parameter BUF_RD_DELAY, default 1, meaning out_fm buffer read latency in cycles, with BUF_RD_DELAY <= ACC_DELAY.
REQ-006 The module SHALL have parameter FP_ADD_DELAY, default 14, meaning the latency of the out_fm partial-sum adder.
REQ-007 The clock port SHALL be: clk  input  1  single clock, all logic on rising edge.
REQ-008 The reset port SHALL be: rst  input  1  synchronous, active-low reset.
REQ-009 The start port SHALL be: start  input  1  one-cycle request to process a pixel block.
REQ-010 The pixel-count port SHALL be: num_pix  input  PW  number of output pixels, sampled with start.
REQ-011 The busy port SHALL be: busy  output  1  high from accepted start until done.
REQ-012 The done port SHALL be: done  output  1  one-cycle completion pulse.
REQ-013 The in_fm read-enable port SHALL be: in_fm_rd_ena  output  1  tap read issue strobe.
REQ-014 The in_fm read-address port SHALL be: in_fm_rd_addr  output  AW  linear tap address.
REQ-015 The weight read-address port SHALL be: weight_rd_addr  output  8  tap index, 0..K*K-1.
REQ-016 The kernel-start port SHALL be: kernel_start  output  1  high on tap 0 of each pixel; it drives the datapath kernel_start.
REQ-017 The out_fm read-enable port SHALL be: out_fm_rd_ena  output  1  partial-sum read strobe.
REQ-018 The out_fm read-address port SHALL be: out_fm_rd_addr  output  PW  address of the partial sum being read.
REQ-019 The out_fm write-enable port SHALL be: out_fm_wr_ena  output  1  updated partial-sum write strobe.
REQ-020 The out_fm write-address port SHALL be: out_fm_wr_addr  output  PW  address of the partial sum being written.

Function
REQ-021 The module SHALL implement a state machine with states IDLE, RUN, DRAIN and DONE.
REQ-022 In IDLE, when start=1 and num_pix>0, the module SHALL latch num_pix, clear the tap and pixel counters, and enter RUN on the next cycle.
REQ-023 In IDLE, when start=1 and num_pix=0, the module SHALL enter DONE on the next cycle and issue no reads or writes.
REQ-024 The module SHALL ignore start while in any state other than IDLE.
REQ-025 In RUN, each cycle the module SHALL assert in_fm_rd_ena with weight_rd_addr=tap and in_fm_rd_addr=(pixel*K*K+tap) mod 2^AW, with no bubbles.
REQ-026 The tap counter SHALL wrap from K*K-1 to 0, and the pixel counter SHALL increment on each wrap.
REQ-027 kernel_start SHALL equal in_fm_rd_ena AND (tap==0), registered with the read strobe so it is cycle-aligned with it.
REQ-028 After issuing tap K*K-1 of pixel num_pix-1, the module SHALL move from RUN to DRAIN.
REQ-029 For a pixel p whose last tap issues in cycle t, out_fm_rd_ena SHALL be 1 with out_fm_rd_addr=p in cycle t+ACC_DELAY-BUF_RD_DELAY.
REQ-030 For the same pixel p, out_fm_wr_ena SHALL be 1 with out_fm_wr_addr=p in cycle t+ACC_DELAY+FP_ADD_DELAY.
REQ-031 The timing of REQ-029 and REQ-030 SHALL be produced by valid-plus-address delay lines, so that one write is in flight per pixel and there is no back-pressure.
REQ-032 The module SHALL leave DRAIN for DONE in the cycle after the last out_fm write of the block.
REQ-033 In DONE, the module SHALL assert done for exactly one cycle and return to IDLE.
REQ-034 busy SHALL be high exactly while the state is RUN, DRAIN or DONE.
REQ-035 When not strobed, all address outputs SHALL hold their last value; strobes SHALL be 0 outside their scheduled cycles.
REQ-036 The number of out_fm writes SHALL equal num_pix exactly, and each out_fm read SHALL precede the write to the same address by BUF_RD_DELAY+FP_ADD_DELAY cycles.

Reset
REQ-037 When rst=0 at a clock edge, the module SHALL enter IDLE, zero all counters and all delay-line valid bits, and drive every output to 0.
REQ-038 A reset applied mid-RUN or mid-DRAIN SHALL produce no out_fm_rd_ena or out_fm_wr_ena pulse afterwards.
REQ-039 After rst returns to 1, the module SHALL accept a start in the very next cycle.

Verification
REQ-040 The bench SHALL cover: K=3, num_pix=2, start at cycle 0 -> in_fm_rd_ena high cycles 1..18, kernel_start at cycles 1 and 10, weight addr 0..8 twice, in_fm addr 0..17.
REQ-041 The bench SHALL cover: the same run with defaults -> out_fm_rd at cycles 58 (addr 0) and 67 (addr 1), out_fm_wr at 73 and 82, done at 83, busy from 1 to 83.
REQ-042 The bench SHALL cover: start with num_pix=0 -> done at cycle 1, no rd/wr strobes, busy high only that cycle.
REQ-043 The bench SHALL cover: start pulsed again during RUN -> ignored, and the write count still equals the original num_pix.
REQ-044 The bench SHALL cover: rst=0 at cycle 30 of a num_pix=4 run -> all outputs 0 from cycle 31, no later out_fm strobes, and a new start at cycle 32 is accepted.
REQ-045 The bench SHALL cover: AW=4, num_pix=3 -> in_fm_rd_addr wraps 15 to 0 at the 17th tap.

Source files
------------

// File: rtl/conv_pixel_sched.sv
// Convolution pixel scheduler: issues K*K tap reads per output pixel, then
// schedules the out_fm partial-sum read and write-back for each pixel.
module conv_pixel_sched #(
  parameter int K            = 3,
  parameter int PW           = 12,
  parameter int AW           = 16,
  parameter int ACC_DELAY    = 50,
  parameter int BUF_RD_DELAY = 1,
  parameter int FP_ADD_DELAY = 14
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PW-1:0] num_pix,
  output logic          busy,
  output logic          done,
  output logic          in_fm_rd_ena,
  output logic [AW-1:0] in_fm_rd_addr,
  output logic [7:0]    weight_rd_addr,
  output logic          kernel_start,
  output logic          out_fm_rd_ena,
  output logic [PW-1:0] out_fm_rd_addr,
  output logic          out_fm_wr_ena,
  output logic [PW-1:0] out_fm_wr_addr,
  output logic [1:0]    state_dbg
);

  localparam int KK     = K * K;
  localparam int TW     = (KK > 1) ? $clog2(KK) : 1;
  localparam int RD_STG = ACC_DELAY - BUF_RD_DELAY;
  localparam int WR_STG = ACC_DELAY + FP_ADD_DELAY;
  localparam logic [TW-1:0] TAP_LAST = TW'(KK - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t        state;
  logic [PW-1:0] num_q;
  logic [PW-1:0] pix;
  logic [TW-1:0] tap;
  logic [PW-1:0] wr_cnt;
  logic [PW-1:0] rd_hold;
  logic [PW-1:0] wr_hold;

  // Stage 0 is valid in the cycle a pixel's last tap is on the outputs.
  logic [WR_STG:0] line_vld;
  logic [PW-1:0]   line_addr [0:WR_STG];

  logic          last_tap;
  logic          last_pix;
  logic          nxt_vld;
  logic [TW-1:0] nxt_tap;
  logic [PW-1:0] nxt_pix;

  assign last_tap = (tap == TAP_LAST);
  assign last_pix = (pix == num_q - PW'(1));

  // start is a one-cycle request; it is accepted only in IDLE (busy low),
  // otherwise dropped. There is no back-pressure anywhere downstream.
  always_comb begin
    nxt_vld = 1'b0;
    nxt_pix = pix;
    nxt_tap = last_tap ? '0 : tap + TW'(1);
    if (state == IDLE && start && num_pix != '0) begin
      nxt_vld = (TAP_LAST == '0);
      nxt_pix = '0;
    end else if (state == RUN && !(last_tap && last_pix)) begin
      nxt_vld = (nxt_tap == TAP_LAST);
      nxt_pix = last_tap ? pix + PW'(1) : pix;
    end
  end

  assign out_fm_rd_ena  = line_vld[RD_STG];
  assign out_fm_wr_ena  = line_vld[WR_STG];
  assign out_fm_rd_addr = out_fm_rd_ena ? line_addr[RD_STG] : rd_hold;
  assign out_fm_wr_addr = out_fm_wr_ena ? line_addr[WR_STG] : wr_hold;
  assign busy           = (state != IDLE);
  assign done           = (state == DONE);
  assign state_dbg      = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      num_q          <= '0;
      pix            <= '0;
      tap            <= '0;
      wr_cnt         <= '0;
      rd_hold        <= '0;
      wr_hold        <= '0;
      line_vld       <= '0;
      in_fm_rd_ena   <= 1'b0;
      in_fm_rd_addr  <= '0;
      weight_rd_addr <= '0;
      kernel_start   <= 1'b0;
      for (int i = 0; i <= WR_STG; i++) line_addr[i] <= '0;
    end else begin
      line_vld[0]  <= nxt_vld;
      line_addr[0] <= nxt_pix;
      for (int i = 1; i <= WR_STG; i++) begin
        line_vld[i]  <= line_vld[i-1];
        line_addr[i] <= line_addr[i-1];
      end
      if (out_fm_rd_ena) rd_hold <= line_addr[RD_STG];
      if (out_fm_wr_ena) wr_hold <= line_addr[WR_STG];
      in_fm_rd_ena <= 1'b0;
      kernel_start <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (num_pix != '0) begin
              num_q          <= num_pix;
              tap            <= '0;
              pix            <= '0;
              wr_cnt         <= '0;
              in_fm_rd_ena   <= 1'b1;
              kernel_start   <= 1'b1;
              weight_rd_addr <= '0;
              in_fm_rd_addr  <= '0;
              state          <= RUN;
            end else begin
              state <= DONE;
            end
          end
        end
        RUN: begin
          wr_cnt <= wr_cnt + PW'(out_fm_wr_ena);
          if (last_tap && last_pix) begin
            state <= DRAIN;
          end else begin
            tap            <= nxt_tap;
            pix            <= nxt_pix;
            in_fm_rd_ena   <= 1'b1;
            kernel_start   <= (nxt_tap == '0);
            weight_rd_addr <= 8'(nxt_tap);
            // pixel*K*K+tap advances by exactly one per issued tap.
            in_fm_rd_addr  <= in_fm_rd_addr + AW'(1);
          end
        end
        DRAIN: begin
          wr_cnt <= wr_cnt + PW'(out_fm_wr_ena);
          if (wr_cnt + PW'(out_fm_wr_ena) == num_q) state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_pixel_sched.sv
// Self-checking bench for conv_pixel_sched: a cycle-accurate expectation model
// fills scoreboard queues; monitors pop and compare on every DUT strobe.
module tb_conv_pixel_sched;

  localparam int KK  = 9;
  localparam int ACC = 50;
  localparam int BRD = 1;
  localparam int FPA = 14;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int t0  = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start = 1'b0;
  logic [11:0] num_pix = '0;
  logic        busy, done, in_fm_rd_ena, kernel_start;
  logic        out_fm_rd_ena, out_fm_wr_ena;
  logic [15:0] in_fm_rd_addr;
  logic [7:0]  weight_rd_addr;
  logic [11:0] out_fm_rd_addr, out_fm_wr_addr;
  logic [1:0]  state_dbg;

  conv_pixel_sched dut (
    .clk(clk), .rst(rst), .start(start), .num_pix(num_pix),
    .busy(busy), .done(done),
    .in_fm_rd_ena(in_fm_rd_ena), .in_fm_rd_addr(in_fm_rd_addr),
    .weight_rd_addr(weight_rd_addr), .kernel_start(kernel_start),
    .out_fm_rd_ena(out_fm_rd_ena), .out_fm_rd_addr(out_fm_rd_addr),
    .out_fm_wr_ena(out_fm_wr_ena), .out_fm_wr_addr(out_fm_wr_addr),
    .state_dbg(state_dbg)
  );

  logic        start_w = 1'b0;
  logic [11:0] num_pix_w = '0;
  logic        busy_w, done_w, in_fm_rd_ena_w, kernel_start_w;
  logic        out_fm_rd_ena_w, out_fm_wr_ena_w;
  logic [3:0]  in_fm_rd_addr_w;
  logic [7:0]  weight_rd_addr_w;
  logic [11:0] out_fm_rd_addr_w, out_fm_wr_addr_w;
  logic [1:0]  state_dbg_w;

  conv_pixel_sched #(.AW(4)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .num_pix(num_pix_w),
    .busy(busy_w), .done(done_w),
    .in_fm_rd_ena(in_fm_rd_ena_w), .in_fm_rd_addr(in_fm_rd_addr_w),
    .weight_rd_addr(weight_rd_addr_w), .kernel_start(kernel_start_w),
    .out_fm_rd_ena(out_fm_rd_ena_w), .out_fm_rd_addr(out_fm_rd_addr_w),
    .out_fm_wr_ena(out_fm_wr_ena_w), .out_fm_wr_addr(out_fm_wr_addr_w),
    .state_dbg(state_dbg_w)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [40:0] exp_q[$];     // {rel, kernel_start, weight, in_fm addr}
  logic [27:0] exp_ofr_q[$]; // {rel, out_fm rd addr}
  logic [27:0] exp_ofw_q[$]; // {rel, out_fm wr addr}
  logic [15:0] exp_done_q[$];
  logic [3:0]  exp_w_q[$];
  int busy_end = -1;
  bit mon_on = 1'b0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected schedule of one run; events after cut_rel are not expected.
  task automatic push_model(input int n, input int cut_rel);
    int done_rel;
    for (int p = 0; p < n; p++) begin
      for (int tp = 0; tp < KK; tp++) begin
        int rel;
        rel = 1 + p * KK + tp;
        if (rel <= cut_rel)
          exp_q.push_back({16'(rel), (tp == 0), 8'(tp), 16'(p * KK + tp)});
      end
      if (KK * (p + 1) + ACC - BRD <= cut_rel)
        exp_ofr_q.push_back({16'(KK * (p + 1) + ACC - BRD), 12'(p)});
      if (KK * (p + 1) + ACC + FPA <= cut_rel)
        exp_ofw_q.push_back({16'(KK * (p + 1) + ACC + FPA), 12'(p)});
    end
    done_rel = (n == 0) ? 1 : KK * n + ACC + FPA + 1;
    if (done_rel <= cut_rel) begin
      exp_done_q.push_back(16'(done_rel));
      busy_end = done_rel;
    end else begin
      busy_end = cut_rel;
    end
  endtask

  // monitors
  always @(negedge clk) begin
    if (mon_on) begin
      int rel;
      rel = cyc - t0;
      chk("busy", busy, (rel >= 1 && rel <= busy_end));
      if (in_fm_rd_ena) begin
        if (exp_q.size() == 0) chk("in_fm_spurious", 1, 0);
        else chk("in_fm", {16'(rel), kernel_start, weight_rd_addr, in_fm_rd_addr}, exp_q.pop_front());
      end else if (kernel_start) begin
        chk("kstart_stray", 1, 0);
      end
      if (out_fm_rd_ena) begin
        if (exp_ofr_q.size() == 0) chk("ofm_rd_spurious", 1, 0);
        else chk("ofm_rd", {16'(rel), out_fm_rd_addr}, exp_ofr_q.pop_front());
      end
      if (out_fm_wr_ena) begin
        if (exp_ofw_q.size() == 0) chk("ofm_wr_spurious", 1, 0);
        else chk("ofm_wr", {16'(rel), out_fm_wr_addr}, exp_ofw_q.pop_front());
      end
      if (done) begin
        if (exp_done_q.size() == 0) chk("done_spurious", 1, 0);
        else chk("done", 16'(rel), exp_done_q.pop_front());
      end
      if (in_fm_rd_ena_w) begin
        if (exp_w_q.size() == 0) chk("aw4_spurious", 1, 0);
        else chk("aw4_addr", in_fm_rd_addr_w, exp_w_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_run(input int n, input int cut_rel);
    step(1);
    start   = 1'b1;
    num_pix = 12'(n);
    t0      = cyc;
    push_model(n, cut_rel);
    step(1);
    start   = 1'b0;
  endtask

  task automatic wait_rel(input int r);
    while (cyc - t0 < r) step(1);
  endtask

  task automatic check_drained(input string tag);
    chk({tag, "_in_left"}, exp_q.size(), 0);
    chk({tag, "_rd_left"}, exp_ofr_q.size(), 0);
    chk({tag, "_wr_left"}, exp_ofw_q.size(), 0);
    chk({tag, "_done_left"}, exp_done_q.size(), 0);
  endtask

  initial begin
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ena", in_fm_rd_ena, 0);
    chk("rst_in_addr", in_fm_rd_addr, 0);
    chk("rst_wt_addr", weight_rd_addr, 0);
    chk("rst_kstart", kernel_start, 0);
    chk("rst_ofm_rd", {out_fm_rd_ena, out_fm_rd_addr}, 0);
    chk("rst_ofm_wr", {out_fm_wr_ena, out_fm_wr_addr}, 0);
    chk("rst_state", state_dbg, 0);
    rst    = 1'b1;
    mon_on = 1'b1;

    // two pixels straight after reset release
    start_run(2, 1000);
    wait_rel(KK * 2 + ACC + FPA + 6);
    check_drained("np2");

    // empty block
    start_run(0, 1000);
    wait_rel(5);
    check_drained("np0");

    // start re-pulsed during RUN must be ignored
    start_run(3, 1000);
    step(3);
    start = 1'b1; num_pix = 12'd7;
    step(1);
    start = 1'b0;
    wait_rel(KK * 3 + ACC + FPA + 10);
    check_drained("restart");

    // reset at cycle 30 of a four-pixel run, new start at cycle 32
    start_run(4, 30);
    wait_rel(30);
    rst = 1'b0;
    step(1);
    chk("mid_rst_outs", {busy, done, in_fm_rd_ena, kernel_start, out_fm_rd_ena,
                         out_fm_wr_ena, in_fm_rd_addr, weight_rd_addr,
                         out_fm_rd_addr, out_fm_wr_addr}, 0);
    rst = 1'b1;
    chk("mid_rst_left", exp_q.size(), 0);
    start_run(1, 1000);
    wait_rel(KK + ACC + FPA + 6);
    check_drained("after_rst");

    // random block sizes
    for (int r = 0; r < 2; r++) begin
      int n;
      n = $urandom_range(1, 5);
      start_run(n, 1000);
      wait_rel(KK * n + ACC + FPA + 6);
      check_drained("rand");
    end

    // narrow in_fm address: wraps 15 -> 0 at the 17th tap
    for (int i = 0; i < 3 * KK; i++) exp_w_q.push_back(4'(i));
    step(1);
    start_w = 1'b1; num_pix_w = 12'd3;
    step(1);
    start_w = 1'b0;
    step(3 * KK + ACC + FPA + 6);
    chk("aw4_left", exp_w_q.size(), 0);
    chk("aw4_idle", busy_w, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
